// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// valid/ready handshake on both sides, one operation in flight.
module mdu_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      DivSel,
    input  logic            Div32,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int HW = 32;
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ONE  = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [XLEN-1:0]     result_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     b_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          sel_q;
    logic                is_w_q;
    logic                neg_res_q;
    logic                neg_rem_q;

    logic [2:0]          eff_sel_s;
    logic                s1_signed_s;
    logic                s2_signed_s;
    logic [XLEN-1:0]     op1_s;
    logic [XLEN-1:0]     op2_s;
    logic                neg1_s;
    logic                neg2_s;
    logic [XLEN-1:0]     mag1_s;
    logic [XLEN-1:0]     mag2_s;
    logic [XLEN-1:0]     min_s;
    logic                div_zero_s;
    logic                ovf_s;
    logic                special_s;
    logic [XLEN-1:0]     special_res_s;
    logic [2*XLEN-1:0]   acc_init_s;

    logic [XLEN:0]       mul_sum_s;
    logic [XLEN:0]       div_trial_s;
    logic [2*XLEN-1:0]   acc_d;
    logic [CW-1:0]       last_cnt_s;

    logic [2*XLEN-1:0]   mul_res_s;
    logic [XLEN-1:0]     quo_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     raw_res_s;
    logic [XLEN-1:0]     result_d;

    function automatic logic [XLEN-1:0] sext_w(input logic [HW-1:0] v);
        return {{(XLEN-HW){v[HW-1]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext_w(input logic [HW-1:0] v);
        return {{(XLEN-HW){1'b0}}, v};
    endfunction

    function automatic logic [XLEN-1:0] neg_x(input logic n, input logic [XLEN-1:0] v);
        return n ? (~v + ONE) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic n, input logic [2*XLEN-1:0] v);
        return n ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Operand preparation, special-case detection and initial accumulator at acceptance
    always_comb begin
        // W-form multiplies of any flavour collapse to mulw
        eff_sel_s   = (Div32 && !DivSel[2]) ? 3'b000 : DivSel;
        s1_signed_s = eff_sel_s[2] ? !eff_sel_s[0] : (eff_sel_s != 3'b011);
        s2_signed_s = s1_signed_s && (eff_sel_s != 3'b010);

        if (Div32) begin
            op1_s = s1_signed_s ? sext_w(src1[HW-1:0]) : zext_w(src1[HW-1:0]);
            op2_s = s2_signed_s ? sext_w(src2[HW-1:0]) : zext_w(src2[HW-1:0]);
            min_s = {{(XLEN-HW+1){1'b1}}, {(HW-1){1'b0}}};
        end else begin
            op1_s = src1;
            op2_s = src2;
            min_s = {1'b1, {(XLEN-1){1'b0}}};
        end

        neg1_s = s1_signed_s && op1_s[XLEN-1];
        neg2_s = s2_signed_s && op2_s[XLEN-1];
        mag1_s = neg_x(neg1_s, op1_s);
        mag2_s = neg_x(neg2_s, op2_s);

        div_zero_s = eff_sel_s[2] && (op2_s == ZERO);
        ovf_s      = eff_sel_s[2] && !eff_sel_s[0] && (op1_s == min_s) && (op2_s == ONES);
        special_s  = div_zero_s || ovf_s;

        if (div_zero_s) begin
            special_res_s = eff_sel_s[1] ? (Div32 ? sext_w(src1[HW-1:0]) : src1) : ONES;
        end else begin
            special_res_s = eff_sel_s[1] ? ZERO : op1_s;
        end

        // W divides start with the dividend in the upper half so 32 steps reach bit 0
        if (eff_sel_s[2] && Div32) begin
            acc_init_s = {ZERO, mag1_s << HW};
        end else begin
            acc_init_s = {ZERO, mag1_s};
        end
    end

    // One shift-add multiply step or one restoring divide step
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        div_trial_s = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        if (sel_q[2]) begin
            if (div_trial_s[XLEN]) begin
                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            end else begin
                acc_d = {div_trial_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
        end
        last_cnt_s = is_w_q ? CW'(HW - 1) : CW'(XLEN - 1);
    end

    // Sign correction, half/quotient/remainder selection and W sign-extension
    always_comb begin
        // After only 32 multiply steps the product sits 32 bits up in the accumulator
        mul_res_s = neg_2x(neg_res_q, is_w_q ? {ZERO, acc_q[XLEN+HW-1:HW]} : acc_q);
        quo_s     = neg_x(neg_res_q, is_w_q ? zext_w(acc_q[HW-1:0]) : acc_q[XLEN-1:0]);
        rem_s     = neg_x(neg_rem_q, acc_q[2*XLEN-1:XLEN]);
        case (sel_q)
            3'b000:                  raw_res_s = mul_res_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011:  raw_res_s = mul_res_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:          raw_res_s = quo_s;
            3'b110, 3'b111:          raw_res_s = rem_s;
            default:                 raw_res_s = ZERO;
        endcase
        result_d = is_w_q ? sext_w(raw_res_s[HW-1:0]) : raw_res_s;
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= ZERO;
            acc_q       <= {(2*XLEN){1'b0}};
            b_q         <= ZERO;
            cnt_q       <= {CW{1'b0}};
            sel_q       <= 3'b000;
            is_w_q      <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= ZERO;
            cnt_q       <= {CW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sel_q      <= eff_sel_s;
                        is_w_q     <= Div32;
                        neg_res_q  <= neg1_s ^ neg2_s;
                        neg_rem_q  <= neg1_s;
                        acc_q      <= acc_init_s;
                        b_q        <= mag2_s;
                        cnt_q      <= {CW{1'b0}};
                        in_ready_q <= 1'b0;
                        if (special_s) begin
                            result_q    <= special_res_s;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_BUSY;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == last_cnt_s) begin
                        state_q <= S_FIX;
                    end else begin
                        state_q <= S_BUSY;
                    end
                end
                S_FIX: begin
                    result_q    <= result_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, random ops against an
// arithmetic reference model, and hand-written handshake/flush/reset sequences.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  DivSel;
    logic        Div32;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int total = 0;
    int bad   = 0;

    mdu_iter #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .DivSel(DivSel), .Div32(Div32), .src1(src1), .src2(src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] sel, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        logic [31:0]  q32, r32;
        logic [63:0]  q, r;
        int           sa32, sb32;
        longint       sa, sb;
        if (!sel[2]) begin
            if (w) begin
                p = {{96{a[31]}}, a[31:0]} * {{96{b[31]}}, b[31:0]};
                return {{32{p[31]}}, p[31:0]};
            end
            ea = (sel == 3'b011) ? {64'd0, a} : {{64{a[63]}}, a};
            eb = (sel == 3'b000 || sel == 3'b001) ? {{64{b[63]}}, b} : {64'd0, b};
            p  = ea * eb;
            return (sel == 3'b000) ? p[63:0] : p[127:64];
        end
        if (w) begin
            if (b[31:0] == 32'd0) begin
                q32 = 32'hFFFF_FFFF;
                r32 = a[31:0];
            end else if (!sel[0]) begin
                if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                    q32 = a[31:0];
                    r32 = 32'd0;
                end else begin
                    sa32 = a[31:0];
                    sb32 = b[31:0];
                    q32  = sa32 / sb32;
                    r32  = sa32 % sb32;
                end
            end else begin
                q32 = a[31:0] / b[31:0];
                r32 = a[31:0] % b[31:0];
            end
            return sel[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end
        if (b == 64'd0) begin
            q = 64'hFFFF_FFFF_FFFF_FFFF;
            r = a;
        end else if (!sel[0]) begin
            if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                q = a;
                r = 64'd0;
            end else begin
                sa = a;
                sb = b;
                q  = sa / sb;
                r  = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return sel[1] ? r : q;
    endfunction

    function automatic int exp_lat(input logic [2:0] sel, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        if (!sel[2]) return w ? 34 : 66;
        if (w) begin
            if (b[31:0] == 32'd0 ||
                (!sel[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) return 1;
            return 34;
        end
        if (b == 64'd0 ||
            (!sel[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)) return 1;
        return 66;
    endfunction

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'h8000_0000_0000_0000;
            3: v = {$urandom, 32'h8000_0000};
            4: v = {32'd0, 28'd0, 4'($urandom_range(0, 15))};
            5: v = {$urandom, 32'd0};
            default: ;
        endcase
        return v;
    endfunction

    // Issue one op with out_ready=1; returns result, cycles to out_valid, and busy-ready violation
    task automatic run_op(input logic [2:0] sel, input logic w, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] res, output int lat,
                          output bit rdy_bad);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            step();
            guard++;
        end
        DivSel    = sel;
        Div32     = w;
        src1      = a;
        src2      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        src1     = {$urandom, $urandom};
        src2     = {$urandom, $urandom};
        DivSel   = 3'($urandom_range(0, 7));
        Div32    = 1'($urandom_range(0, 1));
        lat      = 1;
        rdy_bad  = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_bad = 1'b1;
            step();
            lat++;
        end
        if (in_ready) rdy_bad = 1'b1;
        if (out_valid) begin
            res = result;
        end else begin
            res = 64'd0;
            lat = -1;
        end
        step();
    endtask

    task automatic wait_ov(input string nm);
        int guard;
        guard = 0;
        while (!out_valid && guard < 200) begin
            step();
            guard++;
        end
        chk(nm, {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] res, a, b, e;
        logic [2:0]  sel;
        logic        w;
        int          lat;
        bit          rdy_bad;
        bit          seen;

        vt[0]  = '{3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
        vt[1]  = '{3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 66};
        vt[2]  = '{3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66};
        vt[3]  = '{3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        vt[4]  = '{3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vt[5]  = '{3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1};
        vt[6]  = '{3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        vt[7]  = '{3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
        vt[8]  = '{3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34};
        vt[9]  = '{3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34};
        vt[10] = '{3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 34};
        vt[11] = '{3'b000, 1'b1, 64'hDEAD_BEEF_0001_0000, 64'h0000_0000_0000_8000, 64'hFFFF_FFFF_8000_0000, 34};
        vt[12] = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
        vt[13] = '{3'b100, 1'b1, 64'h0000_0001_8000_0001, 64'h0000_0005_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vt[14] = '{3'b111, 1'b1, 64'h0000_0001_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1};
        vt[15] = '{3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        vt[16] = '{3'b011, 1'b1, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_8000, 64'hFFFF_FFFF_8000_0000, 34};
        vt[17] = '{3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 66};

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        DivSel = 3'b000; Div32 = 1'b0; src1 = 64'd0; src2 = 64'd0;
        step();
        step();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 18; i++) begin
            run_op(vt[i].sel, vt[i].w, vt[i].a, vt[i].b, res, lat, rdy_bad);
            chk($sformatf("vec%0d_result", i), res, vt[i].exp);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
            chk($sformatf("vec%0d_busy_ready", i), {63'd0, rdy_bad}, 64'd0);
        end

        for (int i = 0; i < 40; i++) begin
            sel = 3'($urandom_range(0, 7));
            w   = 1'($urandom_range(0, 1));
            a   = rnd64();
            b   = rnd64();
            e   = model(sel, w, a, b);
            run_op(sel, w, a, b, res, lat, rdy_bad);
            if (res !== e)
                $display("rand%0d op sel=%0d w=%0d a=%h b=%h", i, sel, w, a, b);
            chk($sformatf("rand%0d_result", i), res, e);
            chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_lat(sel, w, a, b)));
        end

        // Backpressure: result held and new requests ignored while out_ready is low
        DivSel = 3'b000; Div32 = 1'b0; src1 = 64'd3; src2 = 64'd5;
        out_ready = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_ov("bp_first_valid");
        src1 = 64'd2; src2 = 64'd3; in_valid = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            step();
            if (!out_valid || result !== 64'd15 || in_ready) seen = 1'b1;
        end
        chk("bp_hold", {63'd0, seen}, 64'd0);
        chk("bp_result", result, 64'd15);
        out_ready = 1'b1;
        step();
        chk("bp_idle_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_idle_valid", {63'd0, out_valid}, 64'd0);
        step();
        chk("bp_accept", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        wait_ov("bp_second_valid");
        chk("bp_second_result", result, 64'd6);
        step();

        // Flush in BUSY cycle 20
        DivSel = 3'b000; Div32 = 1'b0; src1 = 64'd9; src2 = 64'd9; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (19) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_busy_valid", {63'd0, out_valid}, 64'd0);
        seen = 1'b0;
        repeat (80) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_valid", {63'd0, seen}, 64'd0);

        // Flush together with in_valid in IDLE
        DivSel = 3'b101; src1 = 64'd5; src2 = 64'd0; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_ready", {63'd0, in_ready}, 64'd1);
        step();
        chk("flush_idle_valid", {63'd0, out_valid}, 64'd0);

        // Reset asserted mid-operation after a nonzero result
        run_op(3'b000, 1'b0, 64'd11, 64'd13, res, lat, rdy_bad);
        chk("pre_rst_result", res, 64'd143);
        DivSel = 3'b100; Div32 = 1'b0; src1 = 64'd1000; src2 = 64'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_result", result, 64'd0);
        #2;
        rst_n = 1'b1;
        step();
        run_op(3'b100, 1'b0, 64'd1000, 64'd7, res, lat, rdy_bad);
        chk("post_rst_result", res, 64'd142);
        chk("post_rst_latency", 64'(lat), 64'd66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
